// File: rtl/sync_register_bank_rx.sv
// Receive side of a bank of toggle-handshake register transfers.
// Each channel synchronises its request toggle, captures its data word and returns an ack toggle.
module sync_register_bank_rx #(
  parameter int unsigned width     = 8,
  parameter int unsigned channels  = 4,
  parameter int unsigned syncDepth = 2,
  parameter logic [channels*width-1:0] init = '0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [channels-1:0]         sREQ,
  input  logic [channels*width-1:0]   sD_IN,
  input  logic                        dHOLD,
  input  logic [channels-1:0]         dCLR,
  output logic [channels-1:0]         dACK,
  output logic [channels*width-1:0]   dD_OUT,
  output logic [channels-1:0]         dUPDATED,
  output logic [channels-1:0]         dVALID
);

  logic [channels-1:0]       sync_q [syncDepth];
  logic [channels-1:0]       seen_q, seen_d;
  logic [channels-1:0]       upd_q, upd_d;
  logic [channels-1:0]       valid_q, valid_d;
  logic [channels*width-1:0] data_q, data_d;
  logic [channels-1:0]       sync_last;
  logic [channels-1:0]       pend;
  logic [channels-1:0]       load;

  assign sync_last = sync_q[syncDepth-1];
  assign pend      = sync_last ^ seen_q;
  // dHOLD freezes the whole bank so all channels can be read as one snapshot.
  assign load      = pend & {channels{~dHOLD}};

  for (genvar gi = 0; gi < channels; gi++) begin : g_chan
    assign seen_d[gi]  = load[gi] ? sync_last[gi] : seen_q[gi];
    assign upd_d[gi]   = load[gi];
    // A load on the same edge as a clear wins.
    assign valid_d[gi] = load[gi] | (valid_q[gi] & ~dCLR[gi]);
    assign data_d[gi*width +: width] =
      load[gi] ? sD_IN[gi*width +: width] : data_q[gi*width +: width];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < int'(syncDepth); s++) sync_q[s] <= '0;
      seen_q  <= '0;
      upd_q   <= '0;
      valid_q <= '0;
      data_q  <= init;
    end else begin
      sync_q[0] <= sREQ;
      for (int s = 1; s < int'(syncDepth); s++) sync_q[s] <= sync_q[s-1];
      seen_q  <= seen_d;
      upd_q   <= upd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dACK     = seen_q;
  assign dD_OUT   = data_q;
  assign dUPDATED = upd_q;
  assign dVALID   = valid_q;

endmodule

// File: tb/tb_sync_register_bank_rx.sv
// Bench for sync_register_bank_rx: directed handshake scenarios on a depth-2 instance,
// randomised senders on a depth-3 instance, scoreboard of expected loads per channel.
`timescale 1ns/1ps
module tb_sync_register_bank_rx;
  localparam int W = 8;
  localparam int C = 4;
  localparam int N = 1000;
  localparam logic [C*W-1:0] INIT = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [C-1:0]   req2 = '0, clr2 = '0, ack2, upd2, valid2;
  logic           hold2 = 1'b0;
  logic [C*W-1:0] din2 = '0, dout2;
  logic [C-1:0]   req3 = '0, clr3 = '0, ack3, upd3, valid3;
  logic           hold3 = 1'b0;
  logic [C*W-1:0] din3 = '0, dout3;

  sync_register_bank_rx #(.width(W), .channels(C), .syncDepth(2), .init(INIT)) dut2 (
    .CLK(clk), .RST(rst), .sREQ(req2), .sD_IN(din2), .dHOLD(hold2), .dCLR(clr2),
    .dACK(ack2), .dD_OUT(dout2), .dUPDATED(upd2), .dVALID(valid2));

  sync_register_bank_rx #(.width(W), .channels(C), .syncDepth(3), .init(INIT)) dut3 (
    .CLK(clk), .RST(rst), .sREQ(req3), .sD_IN(din3), .dHOLD(hold3), .dCLR(clr3),
    .dACK(ack3), .dD_OUT(dout3), .dUPDATED(upd3), .dVALID(valid3));

  typedef struct {
    int           ch;
    logic [W-1:0] data;
  } sb_t;
  sb_t sb_q[$];

  int errors = 0;
  int checks = 0;
  logic [C*W-1:0] init_v;

  function automatic int sb_find(input int ch);
    for (int i = 0; i < sb_q.size(); i++)
      if (sb_q[i].ch == ch) return i;
    return -1;
  endfunction

  task automatic sb_push(input int ch, input logic [W-1:0] d);
    sb_t e;
    e.ch = ch;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (dout2 !== INIT) begin errors++; $display("FAIL reset_dout: got %h want %h", dout2, INIT); end
    checks++; if (ack2 !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack2); end
    checks++; if (upd2 !== 4'b0000) begin errors++; $display("FAIL reset_upd: got %b want 0000", upd2); end
    checks++; if (valid2 !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", valid2); end
    $display("reset: dout=%h ack=%b upd=%b valid=%b", dout2, ack2, upd2, valid2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int idx;
    din2[1*W +: W] = 8'h3C;
    req2[1] = ~req2[1];
    sb_push(1, 8'h3C);
    tick();
    checks++; if (upd2 !== 4'b0000 || ack2 !== 4'b0000) begin errors++; $display("FAIL single_edge0: got upd=%b ack=%b want 0000/0000", upd2, ack2); end
    tick();
    checks++; if (upd2 !== 4'b0000 || dout2 !== INIT) begin errors++; $display("FAIL single_edge1: got upd=%b dout=%h want 0000/%h", upd2, dout2, INIT); end
    tick();
    checks++; if (upd2 !== 4'b0010) begin errors++; $display("FAIL single_upd: got %b want 0010", upd2); end
    idx = sb_find(1);
    checks++;
    if (idx < 0) begin errors++; $display("FAIL single_sb: no expected entry for ch1"); end
    else begin
      if (dout2[1*W +: W] !== sb_q[idx].data) begin errors++; $display("FAIL single_data: got %h want %h", dout2[1*W +: W], sb_q[idx].data); end
      sb_q.delete(idx);
    end
    checks++; if (ack2 !== 4'b0010 || valid2 !== 4'b0010) begin errors++; $display("FAIL single_ack_valid: got ack=%b valid=%b want 0010/0010", ack2, valid2); end
    checks++; if ({dout2[31:16], dout2[7:0]} !== {init_v[31:16], init_v[7:0]}) begin errors++; $display("FAIL single_others: got %h want %h", {dout2[31:16], dout2[7:0]}, {init_v[31:16], init_v[7:0]}); end
    $display("single: ch1 dout=%h ack=%b valid=%b", dout2[1*W +: W], ack2, valid2);
    tick();
    checks++; if (upd2 !== 4'b0000) begin errors++; $display("FAIL single_upd_pulse: got %b want 0000", upd2); end
  endtask

  task automatic test_hold();
    int idx;
    hold2 = 1'b1;
    din2[0*W +: W] = 8'h11;
    din2[3*W +: W] = 8'h22;
    req2[0] = ~req2[0];
    req2[3] = ~req2[3];
    sb_push(0, 8'h11);
    sb_push(3, 8'h22);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (upd2 !== 4'b0000 || ack2 !== 4'b0010) begin errors++; $display("FAIL hold_blocked cycle %0d: got upd=%b ack=%b want 0000/0010", i, upd2, ack2); end
    end
    hold2 = 1'b0;
    tick();
    hold2 = 1'b1;
    checks++; if (upd2 !== 4'b1001) begin errors++; $display("FAIL hold_release_upd: got %b want 1001", upd2); end
    for (int c = 0; c < C; c += 3) begin
      idx = sb_find(c);
      checks++;
      if (idx < 0) begin errors++; $display("FAIL hold_sb: no expected entry for ch%0d", c); end
      else begin
        if (dout2[c*W +: W] !== sb_q[idx].data) begin errors++; $display("FAIL hold_data ch%0d: got %h want %h", c, dout2[c*W +: W], sb_q[idx].data); end
        sb_q.delete(idx);
      end
    end
    checks++; if (ack2 !== 4'b1011) begin errors++; $display("FAIL hold_ack: got %b want 1011", ack2); end
    $display("hold: released one cycle, upd=%b ack=%b dout=%h", upd2, ack2, dout2);
    tick();
    checks++; if (upd2 !== 4'b0000) begin errors++; $display("FAIL hold_upd_pulse: got %b want 0000", upd2); end
    hold2 = 1'b0;
  endtask

  task automatic test_clear_collision();
    int idx;
    din2[2*W +: W] = 8'h77;
    req2[2] = ~req2[2];
    sb_push(2, 8'h77);
    tick();
    tick();
    clr2 = 4'b0100;
    tick();
    clr2 = 4'b0000;
    checks++; if (upd2 !== 4'b0100 || valid2 !== 4'b1111) begin errors++; $display("FAIL clr_collision: got upd=%b valid=%b want 0100/1111", upd2, valid2); end
    idx = sb_find(2);
    checks++;
    if (idx < 0) begin errors++; $display("FAIL clr_sb: no expected entry for ch2"); end
    else begin
      if (dout2[2*W +: W] !== sb_q[idx].data) begin errors++; $display("FAIL clr_data: got %h want %h", dout2[2*W +: W], sb_q[idx].data); end
      sb_q.delete(idx);
    end
    tick();
    clr2 = 4'b0100;
    tick();
    clr2 = 4'b0000;
    checks++; if (valid2 !== 4'b1011) begin errors++; $display("FAIL clr_alone_valid: got %b want 1011", valid2); end
    checks++; if (dout2[2*W +: W] !== 8'h77) begin errors++; $display("FAIL clr_alone_data: got %h want 77", dout2[2*W +: W]); end
    $display("clear: valid=%b ch2 dout=%h", valid2, dout2[2*W +: W]);
  endtask

  task automatic test_random();
    int sent [C];
    int rcvd [C];
    int cyc;
    int idx;
    logic [W-1:0] d;
    logic busy;
    logic extra;
    cyc = 0;
    for (int c = 0; c < C; c++) begin sent[c] = 0; rcvd[c] = 0; end
    sb_q.delete();
    busy = 1'b1;
    while (busy && cyc < 60000) begin
      tick();
      cyc++;
      for (int c = 0; c < C; c++) begin
        if (upd3[c] === 1'b1) begin
          checks++;
          idx = sb_find(c);
          if (idx < 0) begin errors++; $display("FAIL rand_unexpected ch%0d: got update with dout %h want none", c, dout3[c*W +: W]); end
          else begin
            if (dout3[c*W +: W] !== sb_q[idx].data) begin errors++; $display("FAIL rand_data ch%0d #%0d: got %h want %h", c, rcvd[c], dout3[c*W +: W], sb_q[idx].data); end
            sb_q.delete(idx);
          end
          rcvd[c]++;
        end
      end
      for (int c = 0; c < C; c++) begin
        if (sent[c] < N && ack3[c] === req3[c] && $urandom_range(0, 2) == 0) begin
          d = W'($urandom);
          din3[c*W +: W] = d;
          req3[c] = ~req3[c];
          sb_push(c, d);
          sent[c]++;
        end
      end
      hold3 = ($urandom_range(0, 3) == 0);
      busy = 1'b0;
      for (int c = 0; c < C; c++) if (sent[c] < N || rcvd[c] < N) busy = 1'b1;
    end
    hold3 = 1'b0;
    checks++; if (busy) begin errors++; $display("FAIL rand_timeout: got still busy after %0d cycles want done", cyc); end
    extra = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (upd3 !== 4'b0000) extra = 1'b1;
    end
    checks++; if (extra) begin errors++; $display("FAIL rand_extra_pulse: got extra dUPDATED want none"); end
    for (int c = 0; c < C; c++) begin
      checks++; if (rcvd[c] != N) begin errors++; $display("FAIL rand_count ch%0d: got %0d want %0d", c, rcvd[c], N); end
      checks++; if (ack3[c] !== 1'(N % 2)) begin errors++; $display("FAIL rand_ack_parity ch%0d: got %b want %b", c, ack3[c], 1'(N % 2)); end
      $display("random ch%0d: sent=%0d received=%0d ack=%b", c, sent[c], rcvd[c], ack3[c]);
    end
    checks++; if (valid3 !== 4'b1111) begin errors++; $display("FAIL rand_valid: got %b want 1111", valid3); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d entries want 0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (dout2 !== INIT) begin errors++; $display("FAIL async_dout: got %h want %h", dout2, INIT); end
    checks++; if (ack2 !== 4'b0000 || upd2 !== 4'b0000 || valid2 !== 4'b0000) begin errors++; $display("FAIL async_flags: got ack=%b upd=%b valid=%b want 0000", ack2, upd2, valid2); end
    $display("async reset: dout=%h ack=%b valid=%b", dout2, ack2, valid2);
    sb_q.delete();
    req2 = '0; din2 = '0; req3 = '0; din3 = '0;
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_pending();
    int idx;
    rst = 1'b1;
    req2 = 4'b0001;
    din2[0*W +: W] = 8'h5A;
    sb_q.delete();
    sb_push(0, 8'h5A);
    tick();
    rst = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 2) begin
        checks++; if (upd2 !== 4'b0001 || ack2 !== 4'b0001) begin errors++; $display("FAIL rstpend_load: got upd=%b ack=%b want 0001/0001", upd2, ack2); end
        idx = sb_find(0);
        checks++;
        if (idx < 0) begin errors++; $display("FAIL rstpend_sb: no expected entry for ch0"); end
        else begin
          if (dout2[0*W +: W] !== sb_q[idx].data) begin errors++; $display("FAIL rstpend_data: got %h want %h", dout2[0*W +: W], sb_q[idx].data); end
          sb_q.delete(idx);
        end
        $display("reset pending: load at edge %0d dout0=%h", e, dout2[0*W +: W]);
      end else begin
        checks++; if (upd2 !== 4'b0000) begin errors++; $display("FAIL rstpend_edge%0d: got upd=%b want 0000", e, upd2); end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_v = INIT;
    test_reset();
    test_single();
    test_hold();
    test_clear_collision();
    test_random();
    test_async_reset();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
